depuncturer: RTL and testbench

- Stage directly downstream of the deinterleaver in the 802.11a receive chain.
- Captures one 96-bit deinterleaved OFDM symbol (QPSK, 48 subcarriers x 2 bits) when the deinterleaver pulses its ready.
- Serialises it into (A,B) coded-bit pairs, one pair per clock, for the Viterbi decoder.
- Reinserts erasures at punctured positions for rates 2/3 and 3/4.

---
 rtl/wlan_rx_pkg.sv | 30 +++
 rtl/depunc_pattern.sv | 52 +++++
 rtl/depuncturer.sv | 198 +++++++++++++++++++
 tb/tb_depuncturer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wlan_rx_pkg.sv
// Shared 802.11a receive-chain definitions used by the depuncturer:
// rate codes, QPSK block size, per-rate pair totals and FSM state encoding.
package wlan_rx_pkg;

   localparam int NCBPS_QPSK = 96;
   localparam int PAIRS_1_2  = NCBPS_QPSK / 2;
   localparam int PAIRS_2_3  = NCBPS_QPSK * 2 / 3;
   localparam int PAIRS_3_4  = NCBPS_QPSK * 3 / 4;

   typedef enum logic [1:0] {
      RATE_1_2 = 2'b00,
      RATE_2_3 = 2'b01,
      RATE_3_4 = 2'b10
   } rate_e;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } depunc_state_e;

   // The unused code 2'b11 falls back to rate 1/2.
   function automatic rate_e decode_rate(input logic [1:0] code);
      case (code)
         2'b01:   return RATE_2_3;
         2'b10:   return RATE_3_4;
         default: return RATE_1_2;
      endcase
   endfunction

endpackage

// File: rtl/depunc_pattern.sv
// Puncture pattern lookup: for a rate and phase, how many buffered bits the
// current (A,B) pair consumes, where A/B come from, and which one is erased.
module depunc_pattern
   import wlan_rx_pkg::*;
(
   input  rate_e      rate_i,
   input  logic [1:0] phase_i,
   output logic [1:0] consume_o,
   output logic       a_off_o,
   output logic       b_off_o,
   output logic       a_erase_o,
   output logic       b_erase_o,
   output logic       phase_last_o
);

   always_comb begin
      consume_o    = 2'd2;
      a_off_o      = 1'b0;
      b_off_o      = 1'b1;
      a_erase_o    = 1'b0;
      b_erase_o    = 1'b0;
      phase_last_o = 1'b1;
      case (rate_i)
         RATE_2_3: begin
            if (phase_i == 2'd0) begin
               phase_last_o = 1'b0;
            end else begin
               consume_o = 2'd1;
               b_erase_o = 1'b1;
            end
         end
         RATE_3_4: begin
            case (phase_i)
               2'd0: phase_last_o = 1'b0;
               2'd1: begin
                  consume_o    = 2'd1;
                  b_erase_o    = 1'b1;
                  phase_last_o = 1'b0;
               end
               default: begin
                  // A is punctured, so B takes the next unread bit.
                  consume_o = 2'd1;
                  a_erase_o = 1'b1;
                  b_off_o   = 1'b0;
               end
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/depuncturer.sv
// Depuncturer: holds one deinterleaved block and emits (A,B) pairs with erasures.
// Define DEPUNC_DBUF_EN to add a shadow buffer for gapless back-to-back blocks.
module depuncturer
   import wlan_rx_pkg::*;
#(
   parameter int NCBPS = NCBPS_QPSK,
   parameter int CNT_W = 7
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             en,
   input  logic [NCBPS-1:0] in_data,
   input  logic             in_valid,
   input  logic [1:0]       rate,
   output logic [1:0]       out_data,
   output logic [1:0]       out_erase,
   output logic             out_valid,
   output logic             busy,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] TOT_12 = CNT_W'(PAIRS_1_2 * NCBPS / NCBPS_QPSK);
   localparam logic [CNT_W-1:0] TOT_23 = CNT_W'(PAIRS_2_3 * NCBPS / NCBPS_QPSK);
   localparam logic [CNT_W-1:0] TOT_34 = CNT_W'(PAIRS_3_4 * NCBPS / NCBPS_QPSK);

   depunc_state_e    state_q, state_d;
   logic [NCBPS-1:0] buf_q, buf_d;
   rate_e            rate_q, rate_d;
   logic [CNT_W-1:0] total_q, total_d;
   logic [CNT_W-1:0] bp_q, bp_d;
   logic [CNT_W-1:0] pc_q, pc_d;
   logic [1:0]       phase_q, phase_d;
   logic             ovf_q, ovf_d;
   logic [1:0]       data_q, data_d;
   logic [1:0]       erase_q, erase_d;

   logic [1:0]       consume;
   logic             a_off, b_off, a_erase, b_erase, phase_last;
   logic             emit, last_pair, a_bit, b_bit;
   logic [1:0]       cur_data, cur_erase;
   logic             load;
   logic [NCBPS-1:0] load_buf;
   rate_e            load_rate;

`ifdef DEPUNC_DBUF_EN
   logic [NCBPS-1:0] sbuf_q, sbuf_d;
   rate_e            srate_q, srate_d;
   logic             sfull_q, sfull_d;
`endif

   function automatic logic [CNT_W-1:0] total_of(input rate_e r);
      case (r)
         RATE_2_3: return TOT_23;
         RATE_3_4: return TOT_34;
         default:  return TOT_12;
      endcase
   endfunction

   depunc_pattern u_pattern (
      .rate_i       (rate_q),
      .phase_i      (phase_q),
      .consume_o    (consume),
      .a_off_o      (a_off),
      .b_off_o      (b_off),
      .a_erase_o    (a_erase),
      .b_erase_o    (b_erase),
      .phase_last_o (phase_last)
   );

   // The buffer shifts down as bits are consumed, so bit 0 is always buf[bp].
   assign emit      = (state_q == EMIT) && en;
   assign last_pair = (pc_q == total_q - CNT_W'(1));
   assign a_bit     = a_erase ? 1'b0 : (a_off ? buf_q[1] : buf_q[0]);
   assign b_bit     = b_erase ? 1'b0 : (b_off ? buf_q[1] : buf_q[0]);
   assign cur_data  = {b_bit, a_bit};
   assign cur_erase = {b_erase, a_erase};

   always_comb begin
      state_d   = state_q;
      buf_d     = buf_q;
      rate_d    = rate_q;
      total_d   = total_q;
      bp_d      = bp_q;
      pc_d      = pc_q;
      phase_d   = phase_q;
      ovf_d     = ovf_q;
      data_d    = data_q;
      erase_d   = erase_q;
      load      = 1'b0;
      load_buf  = in_data;
      load_rate = decode_rate(rate);
`ifdef DEPUNC_DBUF_EN
      sbuf_d    = sbuf_q;
      srate_d   = srate_q;
      sfull_d   = sfull_q;
`endif
      case (state_q)
         IDLE: load = in_valid;
         EMIT: begin
            if (emit) begin
               data_d  = cur_data;
               erase_d = cur_erase;
               buf_d   = buf_q >> consume;
               bp_d    = bp_q + CNT_W'(consume);
               pc_d    = pc_q + CNT_W'(1);
               phase_d = phase_last ? 2'd0 : phase_q + 2'd1;
            end
`ifdef DEPUNC_DBUF_EN
            if (emit && last_pair) begin
               if (sfull_q) begin
                  load      = 1'b1;
                  load_buf  = sbuf_q;
                  load_rate = srate_q;
                  sfull_d   = 1'b0;
                  if (in_valid) begin
                     sbuf_d  = in_data;
                     srate_d = decode_rate(rate);
                     sfull_d = 1'b1;
                  end
               end else if (in_valid) begin
                  load = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else if (in_valid) begin
               if (sfull_q) begin
                  ovf_d = 1'b1;
               end else begin
                  sbuf_d  = in_data;
                  srate_d = decode_rate(rate);
                  sfull_d = 1'b1;
               end
            end
`else
            if (emit && last_pair) state_d = IDLE;
            if (in_valid) ovf_d = 1'b1;
`endif
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         state_d = EMIT;
         buf_d   = load_buf;
         rate_d  = load_rate;
         total_d = total_of(load_rate);
         bp_d    = '0;
         pc_d    = '0;
         phase_d = '0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= IDLE;
         rate_q  <= RATE_1_2;
         total_q <= '0;
         bp_q    <= '0;
         pc_q    <= '0;
         phase_q <= '0;
         ovf_q   <= 1'b0;
         data_q  <= '0;
         erase_q <= '0;
`ifdef DEPUNC_DBUF_EN
         srate_q <= RATE_1_2;
         sfull_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rate_q  <= rate_d;
         total_q <= total_d;
         bp_q    <= bp_d;
         pc_q    <= pc_d;
         phase_q <= phase_d;
         ovf_q   <= ovf_d;
         data_q  <= data_d;
         erase_q <= erase_d;
`ifdef DEPUNC_DBUF_EN
         srate_q <= srate_d;
         sfull_q <= sfull_d;
`endif
      end
   end

   // Block storage needs no reset; it is always reloaded before use.
   always_ff @(posedge Clk) begin
      buf_q <= buf_d;
`ifdef DEPUNC_DBUF_EN
      sbuf_q <= sbuf_d;
`endif
   end

   assign out_valid = emit;
   assign out_data  = emit ? cur_data : data_q;
   assign out_erase = emit ? cur_erase : erase_q;
   assign busy      = (state_q == EMIT);
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_depuncturer.sv
// Bench for depuncturer: directed scenarios plus random blocks, scored against
// a puncture-matrix model of the 802.11a depuncturing rules.
module tb_depuncturer;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        en;
   logic [95:0] in_data;
   logic        in_valid;
   logic [1:0]  rate;
   logic [1:0]  out_data;
   logic [1:0]  out_erase;
   logic        out_valid;
   logic        busy;
   logic        overflow;

   depuncturer dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .en        (en),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .rate      (rate),
      .out_data  (out_data),
      .out_erase (out_erase),
      .out_valid (out_valid),
      .busy      (busy),
      .overflow  (overflow)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- scoreboard state ----------------
   logic [3:0] exp_q[$];
   logic [3:0] last_exp = '0;
   int n_checks = 0;
   int n_pass   = 0;
   int pcount, first_cyc, last_cyc, acc_cyc;
   int nz_idx, nz_cnt, stall_seen;
   bit stall_chk = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Reference: 802.11a puncture matrices. For pair k with period P, slot
   // j = k mod P; a present bit takes the next stream bit, a missing one is erased.
   task automatic model_push(input logic [95:0] d, input logic [1:0] code, output int npairs);
      int period;
      logic [2:0] pa, pb;
      int idx, k, j;
      logic a, b, ea, eb;
      case (code)
         2'b01:   begin period = 2; pa = 3'b011; pb = 3'b001; end
         2'b10:   begin period = 3; pa = 3'b011; pb = 3'b101; end
         default: begin period = 1; pa = 3'b001; pb = 3'b001; end
      endcase
      idx = 0;
      k = 0;
      while (idx < 96) begin
         j = k % period;
         if (pa[j]) begin a = d[idx]; ea = 1'b0; idx++; end
         else begin a = 1'b0; ea = 1'b1; end
         if (pb[j]) begin b = d[idx]; eb = 1'b0; idx++; end
         else begin b = 1'b0; eb = 1'b1; end
         exp_q.push_back({eb, ea, b, a});
         k++;
      end
      npairs = k;
   endtask

   always @(negedge Clk) begin
      logic [3:0] e;
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check("extra_pair", {out_erase, out_data}, 4'hx);
         end else begin
            e = exp_q.pop_front();
            check("pair", {out_erase, out_data}, e);
            last_exp = e;
         end
         if (pcount == 0) first_cyc = cyc;
         last_cyc = cyc;
         if (out_data != 2'b00) begin nz_idx = pcount; nz_cnt++; end
         pcount++;
      end
      if (stall_chk) begin
         check("stall_valid", out_valid, 1'b0);
         check("stall_hold", {out_erase, out_data}, last_exp);
         if (busy && !out_valid) stall_seen++;
      end
   end

   // ---------------- driver tasks (called at posedge + #1) ----------------
   function automatic logic [95:0] rand96();
      return {$urandom, $urandom, $urandom};
   endfunction

   task automatic start_block(input logic [95:0] d, input logic [1:0] code, output int n);
      in_data  = d;
      rate     = code;
      in_valid = 1'b1;
      acc_cyc  = cyc;
      pcount   = 0;
      nz_cnt   = 0;
      nz_idx   = -1;
      first_cyc = -1;
      model_push(d, code, n);
      @(posedge Clk); #1;
      in_valid = 1'b0;
      rate     = $urandom_range(0, 3);
   endtask

   task automatic wait_pairs(input int n);
      int guard = 0;
      while (pcount < n && guard < 300) begin
         @(posedge Clk); #1;
         guard++;
      end
      if (pcount < n) check("wait_pairs_timeout", pcount, n);
   endtask

   task automatic wait_idle(input bit rand_en);
      int guard = 0;
      while (busy && guard < 400) begin
         if (rand_en) en = ($urandom_range(0, 3) != 0);
         @(posedge Clk); #1;
         guard++;
      end
      en = 1'b1;
      if (busy) check("idle_timeout", busy, 1'b0);
      repeat (2) begin @(posedge Clk); #1; end
      check("leftover", exp_q.size(), 0);
   endtask

   task automatic collide_run(input logic [1:0] code, input int at_pair, input string tag);
      int n1, n2;
      logic [95:0] d2;
      start_block(rand96(), code, n1);
      wait_pairs(at_pair);
      d2 = rand96();
      in_data  = d2;
      rate     = code;
      in_valid = 1'b1;
`ifdef DEPUNC_DBUF_EN
      model_push(d2, code, n2);
`else
      n2 = 0;
`endif
      @(posedge Clk); #1;
      in_valid = 1'b0;
      wait_idle(0);
      check({tag, "_count"}, pcount, n1 + n2);
`ifdef DEPUNC_DBUF_EN
      check({tag, "_ovf"}, overflow, 1'b0);
      check({tag, "_gapless"}, last_cyc - first_cyc, n1 + n2 - 1);
`else
      check({tag, "_ovf"}, overflow, 1'b1);
`endif
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      logic [95:0] d;
      Rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = '0; rate = 2'b00;
      pcount = 0; first_cyc = -1; last_cyc = 0; nz_idx = -1; nz_cnt = 0; stall_seen = 0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check("rst_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_ovf", overflow, 1'b0);
      check("rst_data", {out_erase, out_data}, 4'h0);
      @(posedge Clk); #1;
      Rst = 1'b0;
      @(posedge Clk); #1;

      // Rate 1/2 alternating bits: every pair is B=1, A=0.
      start_block({24{4'hA}}, 2'b00, n);
      wait_idle(0);
      check("r12_count", pcount, 48);
      check("r12_lat_first", first_cyc - acc_cyc, 1);
      check("r12_lat_last", last_cyc - acc_cyc, 48);

      // Rate 3/4 all ones: erasure pattern 00,10,01 repeats.
      start_block({96{1'b1}}, 2'b10, n);
      wait_idle(0);
      check("r34_count", pcount, 72);
      check("r34_lat_first", first_cyc - acc_cyc, 1);
      check("r34_lat_last", last_cyc - acc_cyc, 72);

      // Rate 2/3 walking one at bit 5 lands on pair 3's A.
      d = 96'd1 << 5;
      start_block(d, 2'b01, n);
      wait_idle(0);
      check("r23_count", pcount, 64);
      check("r23_nz_idx", nz_idx, 3);
      check("r23_nz_cnt", nz_cnt, 1);

      // Rate 1/2 with a 3-cycle stall at pair 10.
      start_block(rand96(), 2'b00, n);
      wait_pairs(10);
      stall_seen = 0;
      stall_chk = 1'b1;
      en = 1'b0;
      repeat (3) begin @(posedge Clk); #1; end
      en = 1'b1;
      stall_chk = 1'b0;
      wait_idle(0);
      check("stall_cycles", stall_seen, 3);
      check("stall_count", pcount, 48);
      check("stall_lat_last", last_cyc - acc_cyc, 51);

      // Collisions: one on the final-pair cycle, one mid-block.
      collide_run(2'b00, 47, "final_pair");
      collide_run(2'b00, 20, "mid_block");

      // Reset in the middle of a rate 3/4 block.
      start_block(rand96(), 2'b10, n);
      wait_pairs(30);
      Rst = 1'b1;
      @(posedge Clk); #1;
      exp_q.delete();
      @(negedge Clk);
      check("midrst_busy", busy, 1'b0);
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_ovf", overflow, 1'b0);
      @(posedge Clk); #1;
      Rst = 1'b0;
      @(posedge Clk); #1;
      start_block(rand96(), 2'b01, n);
      wait_idle(0);
      check("postrst_count", pcount, 64);
      check("postrst_lat_first", first_cyc - acc_cyc, 1);

      // Random blocks, random rate (including 2'b11), random stalls.
      for (int i = 0; i < 8; i++) begin
         start_block(rand96(), 2'($urandom_range(0, 3)), n);
         wait_idle(1);
         check("rand_count", pcount, n);
      end
      check("final_ovf", overflow, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
